// File: rtl/warp_state_pkg.sv
// Shared types for the warp state controller.
// Holds the FSM states, the arbiter grant encoding and the warp-id width helper.
package warp_state_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    typedef enum logic {
        GRANT_SPAWN = 1'b0,
        GRANT_TMC   = 1'b1
    } grant_e;

    // Warp-id width, kept at least one bit wide so a port can always be declared.
    function automatic int wid_bits(input int num_warps);
        return (num_warps > 1) ? $clog2(num_warps) : 1;
    endfunction

    localparam int DEFAULT_NUM_WARPS = 4;
    localparam int DEFAULT_WID_BITS  = wid_bits(DEFAULT_NUM_WARPS);

endpackage

// File: rtl/warp_state_rr_arb.sv
// Two-requester round-robin arbiter between warp-spawn and TMC.
// rr_last names the most recent contention winner and only moves on contention.
module warp_state_rr_arb
    import warp_state_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic enable,
    input  logic req_spawn,
    input  logic req_tmc,
    output logic grant_spawn,
    output logic grant_tmc
);

    grant_e rr_last;
    logic   contention;

    assign contention = enable && req_spawn && req_tmc;

    always_comb begin
        grant_spawn = 1'b0;
        grant_tmc   = 1'b0;
        if (contention) begin
            if (rr_last == GRANT_TMC) begin
                grant_spawn = 1'b1;
            end else begin
                grant_tmc = 1'b1;
            end
        end else if (enable) begin
            grant_spawn = req_spawn;
            grant_tmc   = req_tmc;
        end
    end

    // Reset to TMC so spawn wins the very first contention.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_last <= GRANT_TMC;
        end else if (contention) begin
            rr_last <= grant_spawn ? GRANT_SPAWN : GRANT_TMC;
        end
    end

endmodule

// File: rtl/warp_state_ctrl.sv
// Per-warp activation state, thread masks and scheduler perf counters for one core.
// Sequences IDLE -> RUN -> DONE and applies arbitrated spawn / TMC requests.
module warp_state_ctrl
    import warp_state_pkg::*;
#(
    parameter int NUM_WARPS       = 4,
    parameter int NUM_THREADS     = 4,
    parameter int PERF_CTR_BITS   = 44,
    parameter int COMMIT_CNT_BITS = 3,
    parameter int WID_BITS        = wid_bits(NUM_WARPS)
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               start,
    input  logic                               wspawn_valid,
    input  logic [NUM_WARPS-1:0]               wspawn_wmask,
    output logic                               wspawn_ready,
    input  logic                               tmc_valid,
    input  logic [WID_BITS-1:0]                tmc_wid,
    input  logic [NUM_THREADS-1:0]             tmc_tmask,
    output logic                               tmc_ready,
    input  logic                               commit_valid,
    input  logic [COMMIT_CNT_BITS-1:0]         commit_cnt,
    output logic [PERF_CTR_BITS-1:0]           cycles,
    output logic [PERF_CTR_BITS-1:0]           instret,
    output logic [NUM_WARPS-1:0]               active_warps,
    output logic [NUM_WARPS*NUM_THREADS-1:0]   thread_masks,
    output logic                               busy
);

    state_e                             state;
    state_e                             next_state;
    logic [NUM_WARPS-1:0]               next_active;
    logic [NUM_WARPS*NUM_THREADS-1:0]   next_masks;
    logic                               in_run;

    assign in_run = (state == RUN);
    assign busy   = in_run;

    // Requests are only ever granted in RUN, which also excludes the start cycle.
    warp_state_rr_arb u_arb (
        .clk         (clk),
        .reset       (reset),
        .enable      (in_run),
        .req_spawn   (wspawn_valid),
        .req_tmc     (tmc_valid),
        .grant_spawn (wspawn_ready),
        .grant_tmc   (tmc_ready)
    );

    always_comb begin
        next_state  = state;
        next_active = active_warps;
        next_masks  = thread_masks;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    next_state                  = RUN;
                    next_active                 = '0;
                    next_active[0]              = 1'b1;
                    next_masks                  = '0;
                    next_masks[NUM_THREADS-1:0] = '1;
                end
            end
            RUN: begin
                if (wspawn_ready) begin
                    for (int w = 0; w < NUM_WARPS; w++) begin
                        if (wspawn_wmask[w] && !active_warps[w]) begin
                            next_active[w]                            = 1'b1;
                            next_masks[w*NUM_THREADS +: NUM_THREADS]  = NUM_THREADS'(1);
                        end
                    end
                end
                // TMC to an inactive warp is accepted but leaves state untouched.
                if (tmc_ready) begin
                    for (int w = 0; w < NUM_WARPS; w++) begin
                        if ((WID_BITS'(w) == tmc_wid) && active_warps[w]) begin
                            if (tmc_tmask != '0) begin
                                next_masks[w*NUM_THREADS +: NUM_THREADS] = tmc_tmask;
                            end else begin
                                next_active[w]                           = 1'b0;
                                next_masks[w*NUM_THREADS +: NUM_THREADS] = '0;
                            end
                        end
                    end
                end
                if (next_active == '0) begin
                    next_state = DONE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            active_warps <= '0;
            thread_masks <= '0;
        end else begin
            state        <= next_state;
            active_warps <= next_active;
            thread_masks <= next_masks;
        end
    end

    // Counters wrap freely; cycles survives restarts, instret counts in every state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cycles  <= '0;
            instret <= '0;
        end else begin
            if (in_run) begin
                cycles <= cycles + 1'b1;
            end
            if (commit_valid) begin
                instret <= instret + {{(PERF_CTR_BITS-COMMIT_CNT_BITS){1'b0}}, commit_cnt};
            end
        end
    end

endmodule

// File: doc/warp_state_ctrl.md
Name: warp_state_ctrl

Overview:
- Owns per-warp activation state and the scheduler performance counters for one core.
- Drives the master side of the scheduler-to-CSR bundle: cycles, instret, active_warps, thread_masks.
- Arbitrates two requesters that mutate warp state, warp-spawn and thread-mask-control (TMC), and sequences the core through IDLE, RUN and DONE.

Parameters:
- NUM_WARPS, 4, number of warps; must be at least 2.
- NUM_THREADS, 4, threads per warp.
- PERF_CTR_BITS, 44, width of the cycles and instret counters.
- COMMIT_CNT_BITS, 3, width of the per-cycle committed-instruction count.

Ports:
- clk  in  1  core clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  single-cycle kernel launch pulse
- wspawn_valid  in  1  spawn request valid
- wspawn_wmask  in  NUM_WARPS  warps to spawn
- wspawn_ready  out  1  spawn request accepted this cycle
- tmc_valid  in  1  TMC request valid
- tmc_wid  in  log2(NUM_WARPS)  target warp
- tmc_tmask  in  NUM_THREADS  new thread mask
- tmc_ready  out  1  TMC request accepted this cycle
- commit_valid  in  1  commit stage retiring instructions
- commit_cnt  in  COMMIT_CNT_BITS  instructions retired this cycle
- cycles  out  PERF_CTR_BITS  RUN-cycle counter
- instret  out  PERF_CTR_BITS  retired-instruction counter
- active_warps  out  NUM_WARPS  per-warp active bit
- thread_masks  out  NUM_WARPS x NUM_THREADS  per-warp thread mask
- busy  out  1  high while state is RUN

Behaviour:
- Reset (asynchronous, active-high):
  - state=IDLE; all outputs 0.
  - rr_last=TMC, so spawn wins the first contention.
- All state updates are registered; an accepted request is visible on the outputs the next cycle.
- State machine:
  - IDLE or DONE, with start=1: go to RUN. Next cycle active_warps=1 (warp 0), thread_masks[0]=all ones, all other masks 0.
  - RUN: start is ignored.
  - RUN to DONE: when the next-state active_warps is 0 (the last warp was deactivated).
- Handshake:
  - The ready outputs are combinational from the valid inputs, state and rr_last.
  - Only in RUN, and never in the start cycle.
  - At most one request is granted per cycle.
  - If only one request is valid, it is granted.
  - If both are valid, the one not named by rr_last is granted; rr_last updates only on contention.
  - Valid/payload must stay stable until ready.
- Spawn grant, for each warp w in wspawn_wmask:
  - If w is inactive: set active_warps[w] and thread_masks[w]=1 (thread 0 only).
  - If w is already active: no change to that warp.
  - wmask=0 is accepted as a no-op.
- TMC grant:
  - tmask!=0 on an active warp: thread_masks[wid]=tmask.
  - tmask=0: clear active_warps[wid] and thread_masks[wid].
  - Any TMC on an inactive warp is accepted and dropped.
- cycles: +1 every cycle state==RUN, including the RUN-to-DONE cycle; frozen in IDLE/DONE; not cleared by start.
- instret: +commit_cnt, zero-extended, whenever commit_valid, in any state.
- Both counters wrap modulo 2^PERF_CTR_BITS with no saturation.
- busy = (state==RUN).
- Invariant: active_warps[w]=0 implies thread_masks[w]=0.

Decomposition:
- Shared package holds:
  - the state enum (IDLE, RUN, DONE);
  - the grant encoding (GRANT_SPAWN, GRANT_TMC);
  - the warp-id width constant.
- One sub-module, warp_state_rr_arb: the two-requester round-robin arbiter with its rr_last flop. All other logic is inline.

Test Plan:
- Reset, then start:
  - Next cycle active_warps=0001, thread_masks[0]=1111, busy=1.
  - After 10 RUN cycles, cycles=10.
- Spawn wmask=0110 while warp 1 is already active:
  - Warp 2 becomes active with mask 0001.
  - Warp 1's mask is unchanged.
  - wspawn_ready is high for exactly one cycle.
- Spawn and TMC valid together for 4 consecutive cycles:
  - Grants alternate spawn, TMC, spawn, TMC.
  - Exactly one ready is high per cycle.
- TMC tmask=0 on warp 0, the only active warp:
  - Next cycle active_warps=0, state=DONE, busy=0.
  - cycles holds its value thereafter.
- instret wrap:
  - Preload instret near 2^PERF_CTR_BITS-2 via force, then commit_valid with commit_cnt=5: instret=3.
  - commit_valid in DONE still increments instret.
- Edge cases:
  - Asynchronous reset mid-RUN, asserted between clock edges: all outputs go to 0 immediately.
  - start with tmc_valid high in the same cycle: tmc_ready=0 that cycle.
  - TMC to an inactive warp 3: accepted, no state change.
